ps2_frame_receiver: RTL and testbench

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_frame_receiver.sv | 192 +++++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 style serial frame receiver: synchronise, debounce, sample on clock fall,
// check parity/stop and hand the payload to a valid/ready consumer.
module ps2_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [7:0] CNT_MAX = 8'(CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            dout  <= 1'b1;
            cnt   <= 8'd0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != dout) begin
                if (cnt == CNT_MAX) begin
                    dout <= sync2;
                    cnt  <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

endmodule

module ps2_frame_receiver #(
    parameter int DATA_BITS       = 8,
    parameter int PARITY_MODE     = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic                 FCLK,
    input  logic                 RST,
    input  logic                 SERIAL_CLK,
    input  logic                 SERIAL_DATA,
    output logic [DATA_BITS-1:0] FRAME_DATA,
    output logic                 FRAME_VALID,
    input  logic                 FRAME_READY,
    output logic                 PARITY_ERROR,
    output logic                 FRAMING_ERROR,
    output logic                 OVERRUN,
    output logic                 BUSY,
    output logic [3:0]           BIT_COUNT
);

    localparam logic [31:0] TMO_MAX   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 clk_f;
    logic                 dat_f;
    logic                 clk_f_d;
    logic                 strobe;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [31:0]          tmo_cnt;
    logic                 timeout;
    logic                 frame_done;
    logic                 ones_odd;
    logic                 par_ok;
    logic                 good;

    ps2_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clk_db (
        .clk  (FCLK),
        .rst  (RST),
        .din  (SERIAL_CLK),
        .dout (clk_f)
    );

    ps2_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dat_db (
        .clk  (FCLK),
        .rst  (RST),
        .din  (SERIAL_DATA),
        .dout (dat_f)
    );

    assign strobe   = clk_f_d & ~clk_f;
    assign BUSY     = (state != IDLE);
    assign timeout  = BUSY && !strobe && (tmo_cnt == TMO_MAX);
    assign ones_odd = ^{shreg, par_bit};
    assign good     = frame_done & dat_f & par_ok;

    always_comb begin
        par_ok = 1'b1;
        if (PARITY_MODE == 1) begin
            par_ok = ones_odd;
        end else if (PARITY_MODE == 2) begin
            par_ok = ~ones_odd;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (!dat_f) state_nxt = DATA;
                end
                DATA: begin
                    if (BIT_COUNT == LAST_DATA)
                        state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge FCLK) begin
        if (RST) begin
            state         <= IDLE;
            clk_f_d       <= 1'b1;
            shreg         <= '0;
            par_bit       <= 1'b0;
            tmo_cnt       <= 32'd0;
            BIT_COUNT     <= 4'd0;
            FRAME_DATA    <= '0;
            FRAME_VALID   <= 1'b0;
            PARITY_ERROR  <= 1'b0;
            FRAMING_ERROR <= 1'b0;
            OVERRUN       <= 1'b0;
        end else begin
            state         <= state_nxt;
            clk_f_d       <= clk_f;
            PARITY_ERROR  <= frame_done & ~par_ok;
            FRAMING_ERROR <= timeout | (frame_done & ~dat_f);

            if (state_nxt == IDLE) begin
                BIT_COUNT <= 4'd0;
            end else if (strobe) begin
                BIT_COUNT <= BIT_COUNT + 4'd1;
            end

            if (state_nxt == IDLE || strobe) begin
                tmo_cnt <= 32'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            if (strobe && state == DATA) begin
                shreg <= {dat_f, shreg[DATA_BITS-1:1]};
            end
            if (strobe && state == PARITY) begin
                par_bit <= dat_f;
            end

            // A completing frame may replace one being accepted this cycle.
            if (good) begin
                if (!FRAME_VALID || FRAME_READY) begin
                    FRAME_DATA  <= shreg;
                    FRAME_VALID <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end else if (FRAME_VALID && FRAME_READY) begin
                FRAME_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: table vectors, random frames
// against a frame-level model, and hand-written timing corner cases.
module tb_ps2_frame_receiver;

    logic       FCLK;
    logic       RST;
    logic       sclk0, sdat0, rdy0;
    logic [7:0] fd0;
    logic       fv0, pe0, fe0, ov0, bz0;
    logic [3:0] bc0;
    logic       sclk1, sdat1, rdy1;
    logic [6:0] fd1;
    logic       fv1, pe1, fe1, ov1, bz1;
    logic [3:0] bc1;

    ps2_frame_receiver #(.TIMEOUT_CYCLES(400)) dut0 (
        .FCLK          (FCLK),
        .RST           (RST),
        .SERIAL_CLK    (sclk0),
        .SERIAL_DATA   (sdat0),
        .FRAME_DATA    (fd0),
        .FRAME_VALID   (fv0),
        .FRAME_READY   (rdy0),
        .PARITY_ERROR  (pe0),
        .FRAMING_ERROR (fe0),
        .OVERRUN       (ov0),
        .BUSY          (bz0),
        .BIT_COUNT     (bc0)
    );

    ps2_frame_receiver #(
        .DATA_BITS      (7),
        .PARITY_MODE    (0),
        .TIMEOUT_CYCLES (400)
    ) dut1 (
        .FCLK          (FCLK),
        .RST           (RST),
        .SERIAL_CLK    (sclk1),
        .SERIAL_DATA   (sdat1),
        .FRAME_DATA    (fd1),
        .FRAME_VALID   (fv1),
        .FRAME_READY   (rdy1),
        .PARITY_ERROR  (pe1),
        .FRAMING_ERROR (fe1),
        .OVERRUN       (ov1),
        .BUSY          (bz1),
        .BIT_COUNT     (bc1)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    int checks = 0;
    int errors = 0;

    int         n_v0 = 0, n_pe0 = 0, n_fe0 = 0;
    int         n_v1 = 0, n_fe1 = 0;
    logic [7:0] last0 = '0;
    logic [6:0] last1 = '0;

    always @(negedge FCLK) begin
        if (pe0) n_pe0++;
        if (fe0) n_fe0++;
        if (fv0) begin
            n_v0++;
            last0 = fd0;
        end
        if (fe1) n_fe1++;
        if (fv1) begin
            n_v1++;
            last1 = fd1;
        end
    end

    typedef struct {
        logic [7:0] d;
        bit         p;
        bit         stop;
        bit         rdy;
        int         e_vcyc;
        bit         e_perr;
        bit         e_ferr;
        bit         e_valid;
        bit         e_ovr;
        logic [7:0] e_data;
    } vec_t;

    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    logic [7:0] m_data  = '0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge FCLK);
        @(negedge FCLK);
    endtask

    task automatic drive_bit(input int sel, input bit b);
        if (sel == 0) sdat0 = b;
        else sdat1 = b;
        repeat (6) @(posedge FCLK);
        if (sel == 0) sclk0 = 1'b0;
        else sclk1 = 1'b0;
        repeat (12) @(posedge FCLK);
        if (sel == 0) sclk0 = 1'b1;
        else sclk1 = 1'b1;
        repeat (6) @(posedge FCLK);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d,
                              input int nbits, input bit has_par,
                              input bit p, input bit stop, input int limit);
        bit q[$];
        q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) q.push_back(d[i]);
        if (has_par) q.push_back(p);
        q.push_back(stop);
        for (int i = 0; i < q.size() && i < limit; i++) drive_bit(sel, q[i]);
        if (sel == 0) sdat0 = 1'b1;
        else sdat1 = 1'b1;
    endtask

    // Frame-level reference: odd parity over payload plus parity bit,
    // plus a one-deep holding slot with sticky overrun.
    task automatic model(input logic [7:0] d, input bit p, input bit stop,
                         input bit rdy, output vec_t v);
        bit par_ok;
        bit good;
        par_ok   = (($countones(d) + int'(p)) % 2) == 1;
        good     = par_ok && stop;
        v.d      = d;
        v.p      = p;
        v.stop   = stop;
        v.rdy    = rdy;
        v.e_perr = !par_ok;
        v.e_ferr = !stop;
        if (rdy) begin
            m_valid  = 1'b0;
            v.e_vcyc = good ? 1 : 0;
            v.e_data = d;
        end else begin
            v.e_vcyc = 0;
            if (good) begin
                if (m_valid) m_ovr = 1'b1;
                else begin
                    m_valid = 1'b1;
                    m_data  = d;
                end
            end
            v.e_data = m_data;
        end
        v.e_valid = m_valid;
        v.e_ovr   = m_ovr;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int sv, sp, sf;
        rdy0 = v.rdy;
        cyc(6);
        sv = n_v0;
        sp = n_pe0;
        sf = n_fe0;
        send_frame(0, {1'b0, v.d}, 8, 1'b1, v.p, v.stop, 99);
        cyc(30);
        if (v.rdy) begin
            check($sformatf("v%0d_vcyc", idx), n_v0 - sv, v.e_vcyc);
            if (v.e_vcyc != 0)
                check($sformatf("v%0d_data", idx), last0, v.e_data);
        end
        check($sformatf("v%0d_perr", idx), n_pe0 - sp, v.e_perr);
        check($sformatf("v%0d_ferr", idx), n_fe0 - sf, v.e_ferr);
        check($sformatf("v%0d_valid", idx), fv0, v.e_valid);
        check($sformatf("v%0d_ovr", idx), ov0, v.e_ovr);
        if (v.e_valid) check($sformatf("v%0d_held", idx), fd0, v.e_data);
        check($sformatf("v%0d_busy", idx), bz0, 0);
    endtask

    vec_t tbl[9];
    vec_t v;
    int   sv, sf, sp;

    initial begin
        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{8'h1C, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C};
        tbl[6] = '{8'hF0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1C};
        tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1C};
        tbl[8] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};

        RST   = 1'b1;
        sclk0 = 1'b1;
        sdat0 = 1'b1;
        rdy0  = 1'b1;
        sclk1 = 1'b1;
        sdat1 = 1'b1;
        rdy1  = 1'b1;
        cyc(5);
        check("rst_valid", fv0, 0);
        check("rst_data", fd0, 0);
        check("rst_ovr", ov0, 0);
        check("rst_busy", bz0, 0);
        check("rst_bitcnt", bc0, 0);
        check("rst_errs", {pe0, fe0, pe1, fe1}, 0);
        RST = 1'b0;
        cyc(10);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        check("hs_before", fv0, 1);
        rdy0 = 1'b1;
        @(negedge FCLK);
        check("hs_after", fv0, 0);
        run_vec(tbl[8], 8);

        m_valid = 1'b0;
        m_ovr   = 1'b1;
        m_data  = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            model(8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, v);
            run_vec(v, 100 + i);
        end

        rdy0 = 1'b1;
        cyc(4);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        cyc(2);
        check("rst2_ovr", ov0, 0);
        check("rst2_valid", fv0, 0);

        sdat0 = 1'b0;
        cyc(12);
        sclk0 = 1'b0;
        cyc(2);
        sclk0 = 1'b1;
        cyc(20);
        check("glitch2_busy", bz0, 0);
        check("glitch2_bitcnt", bc0, 0);
        sclk0 = 1'b0;
        cyc(3);
        sclk0 = 1'b1;
        cyc(20);
        check("glitch3_busy", bz0, 0);
        sdat0 = 1'b1;
        cyc(12);

        sf = n_fe0;
        send_frame(0, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 5);
        check("tmo_busy", bz0, 1);
        check("tmo_bitcnt", bc0, 5);
        cyc(350);
        check("tmo_early", n_fe0 - sf, 0);
        cyc(60);
        check("tmo_ferr", n_fe0 - sf, 1);
        check("tmo_idle", bz0, 0);
        check("tmo_bitcnt0", bc0, 0);
        model(8'h5A, 1'b1, 1'b1, 1'b1, v);
        run_vec(v, 200);

        sf = n_fe0;
        sp = n_pe0;
        send_frame(0, 9'h0F3, 8, 1'b1, 1'b1, 1'b1, 3);
        check("mid_busy", bz0, 1);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        check("mid_idle", bz0, 0);
        check("mid_bitcnt", bc0, 0);
        cyc(450);
        check("mid_noerr", (n_fe0 - sf) + (n_pe0 - sp), 0);

        sv = n_v1;
        sf = n_fe1;
        send_frame(1, 9'h055, 7, 1'b0, 1'b0, 1'b0, 99);
        cyc(30);
        check("b7_stop0_ferr", n_fe1 - sf, 1);
        check("b7_stop0_valid", n_v1 - sv, 0);
        sv = n_v1;
        sf = n_fe1;
        send_frame(1, 9'h055, 7, 1'b0, 1'b0, 1'b1, 99);
        cyc(30);
        check("b7_vcyc", n_v1 - sv, 1);
        check("b7_data", last1, 7'h55);
        check("b7_ferr", n_fe1 - sf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
